// File: rtl/router_input_fifo.sv
// Per-port input buffer for the 5-port mesh router: circular FIFO with
// first-word fall-through head outputs, upstream full indication and sticky error flags.
module router_input_fifo #(
  parameter int PKT_W = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] pkt_i,
  input  logic             pkt_valid_i,
  output logic             full_o,
  output logic [PKT_W-1:0] pkt_o,
  output logic [7:0]       packet_addr_o,
  output logic             packet_valid_o,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

  logic [PKT_W-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             overflow_r;
  logic             underflow_r;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [PKT_W-1:0] head_s;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign pop_ok_s  = pop_i && (count_r != {CNT_W{1'b0}});
  assign push_ok_s = pkt_valid_i && ((count_r < DEPTH_C) || (pop_i && (count_r == DEPTH_C)));

  // Storage write; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst) begin
      mem_r[wr_ptr_r] <= pkt_i;
    end
  end

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (pkt_valid_i && !push_ok_s) begin
        overflow_r <= 1'b1;
      end
      if (pop_i && !pop_ok_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  // Fall-through head: zeroed whenever the buffer is empty.
  always_comb begin
    head_s = {PKT_W{1'b0}};
    if (count_r != {CNT_W{1'b0}}) begin
      head_s = mem_r[rd_ptr_r];
    end else begin
      head_s = {PKT_W{1'b0}};
    end
  end

  assign pkt_o          = head_s;
  assign packet_addr_o  = head_s[PKT_W-1 -: 8];
  assign packet_valid_o = (count_r != {CNT_W{1'b0}});
  assign full_o         = (count_r == DEPTH_C);
  assign count_o        = count_r;
  assign overflow_o     = overflow_r;
  assign underflow_o    = underflow_r;

endmodule
